// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit processor front end: opcodes, instruction
// field positions and the fetch/decode FSM state encoding.
package cpu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_SUBI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 13;
  localparam int unsigned RD_MSB     = 12;
  localparam int unsigned RD_LSB     = 10;
  localparam int unsigned RS_MSB     = 9;
  localparam int unsigned RS_LSB     = 7;
  localparam int unsigned RT_MSB     = 6;
  localparam int unsigned RT_LSB     = 4;
  localparam int unsigned IMM_MSB    = 6;
  localparam int unsigned IMM_LSB    = 0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALTED
  } state_e;

  function automatic logic [15:0] sext_imm7(input logic [6:0] v);
    return {{9{v[6]}}, v};
  endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Instruction-memory request/ack bus plus the decoded-instruction valid/ready
// channel towards the register-file/ALU stage.
interface instr_fetch_decode_if #(
  parameter int unsigned PC_WIDTH = 8
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [15:0]         imem_rdata;
  logic                dec_valid;
  logic                dec_ready;
  logic [2:0]          opcode;
  logic [2:0]          reg1;
  logic [2:0]          reg2;
  logic [2:0]          reg3;
  logic [15:0]         imm;

  // Fetch/decode core side.
  modport master (
    output imem_req, imem_addr, dec_valid, opcode, reg1, reg2, reg3, imm,
    input  imem_ack, imem_rdata, dec_ready
  );

  // Memory and downstream consumer side.
  modport slave (
    input  imem_req, imem_addr, dec_valid, opcode, reg1, reg2, reg3, imm,
    output imem_ack, imem_rdata, dec_ready
  );
endinterface

// File: rtl/instr_field_decode.sv
// Purely combinational split of a 16-bit instruction word into its fields,
// with the opcode class flags used by the fetch FSM.
module instr_field_decode
  import cpu_pkg::*;
(
  input  logic [15:0] instr,
  output logic [2:0]  opcode,
  output logic [2:0]  reg1,
  output logic [2:0]  reg2,
  output logic [2:0]  reg3,
  output logic [15:0] imm,
  output logic        is_alu,
  output logic        is_nop,
  output logic        is_halt
);

  logic [2:0] op;
  assign op = instr[OPCODE_MSB:OPCODE_LSB];

  always_comb begin
    opcode  = op;
    reg1    = instr[RD_MSB:RD_LSB];
    reg2    = instr[RS_MSB:RS_LSB];
    reg3    = '0;
    imm     = '0;
    is_alu  = 1'b0;
    is_nop  = 1'b0;
    is_halt = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        is_alu = 1'b1;
        reg3   = instr[RT_MSB:RT_LSB];
      end
      OP_ADDI, OP_SUBI: begin
        is_alu = 1'b1;
        imm    = sext_imm7(instr[IMM_MSB:IMM_LSB]);
      end
      OP_HALT: is_halt = 1'b1;
      default: is_nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch-and-decode front end: walks the PC over instruction memory, drops NOPs,
// stops on HALT and hands ALU instructions downstream over valid/ready.
module instr_fetch_decode
  import cpu_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  instr_fetch_decode_if.master bus,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 halted
);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                imem_req_q, imem_req_d;
  logic                dec_valid_q, dec_valid_d;
  logic                halted_q, halted_d;
  logic [2:0]          opcode_q, opcode_d;
  logic [2:0]          reg1_q, reg1_d;
  logic [2:0]          reg2_q, reg2_d;
  logic [2:0]          reg3_q, reg3_d;
  logic [15:0]         imm_q, imm_d;

  logic [2:0]  f_opcode, f_reg1, f_reg2, f_reg3;
  logic [15:0] f_imm;
  logic        f_is_alu, f_is_nop, f_is_halt;

  instr_field_decode u_decode (
    .instr   (bus.imem_rdata),
    .opcode  (f_opcode),
    .reg1    (f_reg1),
    .reg2    (f_reg2),
    .reg3    (f_reg3),
    .imm     (f_imm),
    .is_alu  (f_is_alu),
    .is_nop  (f_is_nop),
    .is_halt (f_is_halt)
  );

  // Output flags are computed with the state so every output comes from a flop.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    imem_req_d  = imem_req_q;
    dec_valid_d = dec_valid_q;
    halted_d    = halted_q;
    opcode_d    = opcode_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    reg3_d      = reg3_q;
    imm_d       = imm_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          imem_req_d = 1'b1;
        end
      end
      FETCH: begin
        if (bus.imem_ack) begin
          pc_d = pc_q + 1'b1;
          if (f_is_alu) begin
            state_d     = ISSUE;
            imem_req_d  = 1'b0;
            dec_valid_d = 1'b1;
            opcode_d    = f_opcode;
            reg1_d      = f_reg1;
            reg2_d      = f_reg2;
            reg3_d      = f_reg3;
            imm_d       = f_imm;
          end else if (f_is_halt) begin
            state_d    = HALTED;
            imem_req_d = 1'b0;
            halted_d   = 1'b1;
          end else if (f_is_nop) begin
            state_d = FETCH;
          end
        end
      end
      ISSUE: begin
        if (bus.dec_ready) begin
          state_d     = FETCH;
          dec_valid_d = 1'b0;
          imem_req_d  = 1'b1;
        end
      end
      HALTED: begin
        if (start) begin
          state_d    = FETCH;
          pc_d       = RESET_PC;
          halted_d   = 1'b0;
          imem_req_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        imem_req_d  = 1'b0;
        dec_valid_d = 1'b0;
        halted_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      imem_req_q  <= 1'b0;
      dec_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      opcode_q    <= '0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      reg3_q      <= '0;
      imm_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_req_q  <= imem_req_d;
      dec_valid_q <= dec_valid_d;
      halted_q    <= halted_d;
      opcode_q    <= opcode_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      reg3_q      <= reg3_d;
      imm_q       <= imm_d;
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc_q;
  assign bus.dec_valid = dec_valid_q;
  assign bus.opcode    = opcode_q;
  assign bus.reg1      = reg1_q;
  assign bus.reg2      = reg2_q;
  assign bus.reg3      = reg3_q;
  assign bus.imm       = imm_q;
  assign pc            = pc_q;
  assign halted        = halted_q;

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Fetch-and-decode front end for the 16-bit processor. It walks a program counter through instruction memory over a req/ack handshake, splits each 16-bit word into opcode, register indices and a sign-extended immediate, and presents them with a valid/ready handshake to the register-file/ALU stage directly downstream. It handles NOP and HALT locally and never forwards them.

## Interface
- PC_WIDTH, 8, program counter / instruction memory address width
- RESET_PC, 0, PC value after reset and after restart from HALTED
---
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin fetching; sampled only in IDLE or HALTED
- imem_req  output  1  fetch request
- imem_addr  output  PC_WIDTH  fetch address, equals pc while imem_req=1
- imem_ack  input  1  memory response; imem_rdata is valid in the same cycle
- imem_rdata  input  16  instruction word
- dec_valid  output  1  decoded instruction available
- dec_ready  input  1  downstream accepts; tie to 1 when the consumer never stalls
- opcode  output  3  decoded opcode
- reg1  output  3  destination register index
- reg2  output  3  source register A index
- reg3  output  3  source register B index
- imm  output  16  sign-extended immediate
- pc  output  PC_WIDTH  current program counter
- halted  output  1  HALT retired; fetching stopped

## Operation
- Instruction format: [15:13] opcode, [12:10] rd, [9:7] rs, [6:4] rt, [6:0] imm7.
- Opcode classes:
  - 000 ADD and 011 SUB are register ops: reg3=rt, imm=0.
  - 001 ADDI and 010 SUBI are immediate ops: reg3=0, imm = imm7 sign-extended to 16 bits.
  - 100, 101 and 110 are NOP: not issued.
  - 111 is HALT.
- FSM states and transitions:
  - IDLE: outputs idle. start moves to FETCH.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack, capture the word and set pc <= pc+1. The next state depends on the opcode:
    - ALU op: load the output registers and go to ISSUE.
    - NOP: stay in FETCH.
    - HALT: go to HALTED.
  - ISSUE: dec_valid=1. opcode, reg1–reg3 and imm are held stable until dec_valid && dec_ready, then go to FETCH.
  - HALTED: halted=1, imem_req=0. start sets pc <= RESET_PC, clears halted and goes to FETCH.
- PC wraps from 2^PC_WIDTH−1 to 0 with no flag.
- imem_ack outside FETCH is ignored.
- start outside IDLE and HALTED is ignored.
- The downstream stage executes on each accepted handshake only. Fields are undefined for consumption while dec_valid=0 but are driven from registers (no glitches).

## Timing
- Reset (asynchronous, any state, mid-handshake included):
  - state=IDLE, pc=RESET_PC.
  - imem_req, dec_valid and halted are 0.
  - opcode, reg1, reg2, reg3 and imm are 0.
  - imem_addr=RESET_PC.
- start is high in cycle N → imem_req is high in cycle N+1.
- imem_ack is high in cycle M → dec_valid is high in M+1, and pc has incremented in M+1.
- With zero-wait memory and dec_ready=1, throughput is one ALU instruction per 2 cycles. Each NOP costs 1 cycle.
- Stall: while dec_ready=0 in ISSUE, no fetch is issued and all outputs are frozen.
- If the ack for a HALT arrives at cycle M, then halted=1 and imem_req=0 from M+1. The HALT word is not issued.
- All outputs are registered. No combinational path from an input to an output except imem_addr=pc, which is itself a register.

## Structure
- Shared package cpu_pkg holds:
  - opcode localparams: OP_ADD=000, OP_ADDI=001, OP_SUBI=010, OP_SUB=011, OP_HALT=111;
  - field bit positions;
  - the FSM state encoding: IDLE, FETCH, ISSUE, HALTED.
- One combinational sub-module, instr_field_decode, takes the 16-bit word and returns the opcode, indices, sign-extended immediate, is_alu, is_nop and is_halt. The FSM, PC and output registers stay in the top.

## Test plan
- Reset then start; the memory acks 16'h0530 at once → one cycle later dec_valid=1, opcode=000, reg1=1, reg2=2, reg3=3, imm=0, pc=1.
- Memory word 16'h32FD (ADDI) → opcode=001, reg1=4, reg2=5, reg3=0, imm=16'hFFFD.
- Hold dec_ready=0 for 5 cycles during ISSUE → outputs stable, imem_req=0. On the cycle after dec_ready=1, imem_req=1 with imem_addr=pc.
- Program 16'h8000 (NOP), 16'h0530, 16'hE000 (HALT) → exactly one dec_valid handshake. halted=1 with pc=3. A later start refetches from RESET_PC.
- PC_WIDTH=2 with 5 NOPs → imem_addr sequence 0,1,2,3,0.
- Assert rst_n=0 while imem_req=1 with no ack, then while dec_valid=1 → all outputs go to their reset values immediately (asynchronously). No issue follows until the next start.
